// File: rtl/lif_update_unit.sv
// Leaky integrate-and-fire update unit: latches a 16-lane NSR snapshot and
// writes back one updated membrane voltage per cycle, collecting spikes.
module lif_update_unit #(
  parameter int unsigned LANES      = 16,
  parameter int unsigned DW         = 32,
  parameter int unsigned AW         = 5,
  parameter int unsigned LEAK_SHIFT = 4,
  parameter logic [DW-1:0] V_RESET  = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [AW-1:0]       base_addr,
  input  logic [LANES*DW-1:0] cur_in,
  input  logic [LANES*DW-1:0] vol_in,
  input  logic [DW-1:0]       vt_in,
  input  logic                stall,
  output logic                busy,
  output logic                done,
  output logic                wb_we,
  output logic [AW-1:0]       wb_wa,
  output logic [DW-1:0]       wb_wd,
  output logic [LANES-1:0]    spike_out,
  output logic [4:0]          spike_cnt
);
  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [LW-1:0] lane;
  logic [DW-1:0] cur_r [LANES];
  logic [DW-1:0] vol_r [LANES];
  logic [DW-1:0] vt_r;
  logic [AW-1:0] base_r;

  logic signed [DW-1:0] v, c, vl;
  logic        [DW:0]   sum;
  logic        [DW-1:0] sat;
  logic                 fire;

  // Sum is formed one bit wider so overflow shows as a sign disagreement.
  always_comb begin
    v   = vol_r[lane];
    c   = cur_r[lane];
    vl  = v - (v >>> LEAK_SHIFT);
    sum = {vl[DW-1], vl} + {c[DW-1], c};
    sat = sum[DW-1:0];
    if (sum[DW] != sum[DW-1])
      sat = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    fire = $signed(sat) >= $signed(vt_r);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lane      <= '0;
      done      <= 1'b0;
      wb_we     <= 1'b0;
      wb_wa     <= '0;
      wb_wd     <= '0;
      spike_out <= '0;
      spike_cnt <= '0;
      vt_r      <= '0;
      base_r    <= '0;
      for (int unsigned i = 0; i < LANES; i++) begin
        cur_r[i] <= '0;
        vol_r[i] <= '0;
      end
    end else begin
      done  <= 1'b0;
      wb_we <= 1'b0;
      case (state)
        IDLE: if (start) begin
          for (int unsigned i = 0; i < LANES; i++) begin
            cur_r[i] <= cur_in[DW*i +: DW];
            vol_r[i] <= vol_in[DW*i +: DW];
          end
          vt_r      <= vt_in;
          base_r    <= base_addr;
          spike_out <= '0;
          spike_cnt <= '0;
          lane      <= '0;
          state     <= RUN;
        end
        RUN: if (!stall) begin
          wb_we <= 1'b1;
          wb_wa <= base_r + AW'(lane);
          wb_wd <= fire ? V_RESET : sat;
          if (fire) begin
            spike_out[lane] <= 1'b1;
            spike_cnt       <= spike_cnt + 5'd1;
          end
          if (lane == LW'(LANES - 1)) begin
            lane  <= '0;
            state <= DONE;
          end else begin
            lane <= lane + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lif_update_unit.sv
// Self-checking bench for lif_update_unit: directed vector table, random
// snapshots against an arithmetic LIF model, stall and mid-run reset cases.
module tb_lif_update_unit;
  logic         clk = 0;
  logic         rst, start, stall;
  logic [4:0]   base_addr;
  logic [511:0] cur_in, vol_in;
  logic [31:0]  vt_in;
  logic         busy, done, wb_we;
  logic [4:0]   wb_wa;
  logic [31:0]  wb_wd;
  logic [15:0]  spike_out;
  logic [4:0]   spike_cnt;

  int total = 0;
  int bad   = 0;

  lif_update_unit #(.LANES(16), .DW(32), .AW(5), .LEAK_SHIFT(4), .V_RESET(32'd0)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .cur_in(cur_in), .vol_in(vol_in), .vt_in(vt_in), .stall(stall),
    .busy(busy), .done(done), .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .spike_out(spike_out), .spike_cnt(spike_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]   base;
    logic [31:0]  vt;
    logic [511:0] vol;
    logic [511:0] cur;
    logic [15:0]  exp_spike;
    logic [4:0]   exp_cnt;
    logic [31:0]  exp_wd0;
  } vec_t;

  vec_t tbl [4];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Leak is floor(v/16); the sum is clamped to the 32-bit signed range.
  function automatic void model(input logic [31:0] v, input logic [31:0] c,
                                input logic [31:0] t, output logic [31:0] wd,
                                output bit sp);
    longint vv = longint'($signed(v));
    longint q  = vv / 16;
    longint s;
    if (vv < 0 && (vv % 16) != 0) q = q - 1;
    s = vv - q + longint'($signed(c));
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
    sp = (s >= longint'($signed(t)));
    wd = sp ? 32'd0 : s[31:0];
  endfunction

  task automatic run_op(input logic [4:0] base, input logic [31:0] vt,
                        input logic [511:0] cur, input logic [511:0] vol,
                        input int stall_at, input int stall_len, input bit pulse_start,
                        output logic [15:0] spk, output logic [4:0] cnt,
                        output logic [31:0] wd0);
    logic [31:0] exp_wd [16];
    logic [15:0] exp_spk;
    logic [4:0]  exp_cnt;
    logic [4:0]  exp_wa;
    bit          sp;
    int          idx, done_k, addr_bad, data_bad, busy_bad;
    exp_spk = '0; exp_cnt = '0;
    for (int i = 0; i < 16; i++) begin
      model(vol[32*i +: 32], cur[32*i +: 32], vt, exp_wd[i], sp);
      exp_spk[i] = sp;
      if (sp) exp_cnt++;
    end
    idx = 0; done_k = -1; addr_bad = 0; data_bad = 0; busy_bad = 0; wd0 = 'x;
    base_addr = base; vt_in = vt; cur_in = cur; vol_in = vol; start = 1;
    @(posedge clk); #1;
    start = 0;
    base_addr = 5'($urandom); vt_in = $urandom;
    for (int i = 0; i < 16; i++) begin
      cur_in[32*i +: 32] = $urandom;
      vol_in[32*i +: 32] = $urandom;
    end
    for (int k = 1; k <= 60; k++) begin
      stall = (k >= stall_at && k < stall_at + stall_len);
      start = pulse_start && (k == 3);
      @(posedge clk); #1;
      start = 0;
      if (wb_we) begin
        exp_wa = base + 5'(idx);
        if (idx < 16) begin
          if (wb_wa !== exp_wa) begin
            addr_bad++;
            $display("FAIL wb_wa lane %0d got=%0d exp=%0d", idx, wb_wa, exp_wa);
          end
          if (wb_wd !== exp_wd[idx]) begin
            data_bad++;
            $display("FAIL wb_wd lane %0d got=%0h exp=%0h", idx, wb_wd, exp_wd[idx]);
          end
          if (idx == 0) wd0 = wb_wd;
        end
        idx++;
      end
      if (done) begin
        done_k = k;
        break;
      end
      if (!busy) busy_bad++;
    end
    stall = 0;
    check("lane_addr_errors", 64'(addr_bad), 64'd0);
    check("lane_data_errors", 64'(data_bad), 64'd0);
    check("busy_during_run", 64'(busy_bad), 64'd0);
    check("writeback_count", 64'(idx), 64'd16);
    check("done_cycle", 64'(done_k), 64'(17 + stall_len));
    check("busy_after_done", 64'(busy), 64'd0);
    check("spike_out_model", 64'(spike_out), 64'(exp_spk));
    check("spike_cnt_model", 64'(spike_cnt), 64'(exp_cnt));
    spk = spike_out; cnt = spike_cnt;
    @(posedge clk); #1;
  endtask

  logic [15:0] spk;
  logic [4:0]  cnt;
  logic [31:0] wd0;
  bit          seen;

  initial begin
    rst = 1; start = 0; stall = 0; base_addr = 0; cur_in = '0; vol_in = '0; vt_in = 0;

    // Directed vectors
    tbl[0].base = 5'd0;  tbl[0].vt = 32'd20;
    tbl[1].base = 5'd30; tbl[1].vt = 32'd1000;
    tbl[2].base = 5'd7;  tbl[2].vt = 32'h7FFFFFFF;
    tbl[3].base = 5'd12; tbl[3].vt = 32'h7FFFFFFF;
    for (int i = 0; i < 4; i++) begin
      tbl[i].vol = '0; tbl[i].cur = '0;
    end
    for (int i = 0; i < 16; i++) begin
      tbl[0].vol[32*i +: 32] = 32'(i + 1);
      tbl[0].cur[32*i +: 32] = 32'(i + 1);
      tbl[1].vol[32*i +: 32] = 32'd160;
    end
    tbl[2].vol[31:0] = 32'h7FFFFFF0; tbl[2].cur[31:0] = 32'h7FFFFFFF;
    tbl[3].vol[31:0] = 32'hFFFFFFE0; tbl[3].cur[31:0] = 32'hFFFFFF9C;
    tbl[0].exp_spike = 16'hFE00; tbl[0].exp_cnt = 5'd7; tbl[0].exp_wd0 = 32'd2;
    tbl[1].exp_spike = 16'h0000; tbl[1].exp_cnt = 5'd0; tbl[1].exp_wd0 = 32'd150;
    tbl[2].exp_spike = 16'h0001; tbl[2].exp_cnt = 5'd1; tbl[2].exp_wd0 = 32'd0;
    tbl[3].exp_spike = 16'h0000; tbl[3].exp_cnt = 5'd0; tbl[3].exp_wd0 = 32'hFFFFFF7E;

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_we", 64'(wb_we), 64'd0);
    check("reset_wa_wd", {27'd0, wb_wa, wb_wd}, 64'd0);
    check("reset_spikes", {43'd0, spike_cnt, spike_out}, 64'd0);
    rst = 0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (wb_we || busy || done) seen = 1;
    end
    check("idle_quiet", 64'(seen), 64'd0);

    for (int t = 0; t < 4; t++) begin
      run_op(tbl[t].base, tbl[t].vt, tbl[t].cur, tbl[t].vol, 100, 0, 0, spk, cnt, wd0);
      check("tbl_spike_out", 64'(spk), 64'(tbl[t].exp_spike));
      check("tbl_spike_cnt", 64'(cnt), 64'(tbl[t].exp_cnt));
      check("tbl_wd_lane0", 64'(wd0), 64'(tbl[t].exp_wd0));
    end

    // Stall three edges after lane 4 is visible, with an ignored start pulse
    run_op(5'd3, tbl[0].vt, tbl[0].cur, tbl[0].vol, 6, 3, 1, spk, cnt, wd0);
    check("stall_spike_out", 64'(spk), 64'hFE00);

    // Reset while lane 7 is on the write port
    base_addr = 5'd0; vt_in = 32'd20; cur_in = tbl[0].cur; vol_in = tbl[0].vol;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (8) @(posedge clk);
    #1;
    check("midrst_lane7_visible", {58'd0, wb_we, wb_wa}, {58'd0, 1'b1, 5'd7});
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("midrst_we", 64'(wb_we), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_spikes", {43'd0, spike_cnt, spike_out}, 64'd0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (wb_we || done) seen = 1;
    end
    check("midrst_no_activity", 64'(seen), 64'd0);
    run_op(5'd0, tbl[0].vt, tbl[0].cur, tbl[0].vol, 100, 0, 0, spk, cnt, wd0);
    check("post_rst_cnt", 64'(cnt), 64'd7);

    // Random snapshots
    for (int r = 0; r < 25; r++) begin
      logic [511:0] rc, rv;
      logic [31:0]  rvt;
      for (int i = 0; i < 16; i++) begin
        case ($urandom_range(0, 3))
          0: begin rv[32*i +: 32] = 32'($urandom_range(0, 400)) - 32'd200;
                   rc[32*i +: 32] = 32'($urandom_range(0, 400)) - 32'd200; end
          1: begin rv[32*i +: 32] = 32'h7FFFFF00 + 32'($urandom_range(0, 255));
                   rc[32*i +: 32] = 32'h7FFF0000 + 32'($urandom_range(0, 65535)); end
          2: begin rv[32*i +: 32] = 32'h80000000 + 32'($urandom_range(0, 255));
                   rc[32*i +: 32] = 32'h80000000 + 32'($urandom_range(0, 65535)); end
          default: begin rv[32*i +: 32] = $urandom; rc[32*i +: 32] = $urandom; end
        endcase
      end
      rvt = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 300)) - 32'd100 : $urandom;
      run_op(5'($urandom), rvt, rc, rv, $urandom_range(2, 15), $urandom_range(0, 4),
             1'($urandom_range(0, 1)), spk, cnt, wd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
